// File: rtl/pmcd_rst_seq_pkg.sv
// Shared types and constants for the PMCD reset/release sequencer.
// State encoding is fixed because it is exported on the state port.
package pmcd_rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD_RST  = 3'd2,
        WAIT_REL  = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // Number of bits needed to hold values 0..v-1.
    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Widths sized for the largest legal parameter values.
    localparam int FILT_W    = clog2(256);
    localparam int HOLD_W    = clog2(65536);
    localparam int REL_W     = clog2(65536);
    localparam int TIMEOUT_W = clog2(64'd1 << 20);
    localparam int TMR_W_A   = (HOLD_W > REL_W) ? HOLD_W : REL_W;
    localparam int TMR_W     = (TIMEOUT_W > TMR_W_A) ? TIMEOUT_W : TMR_W_A;

    localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pmcd_seq_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. on
// the last cycle of a loaded interval, so the caller transitions that edge.
module pmcd_seq_timer
    import pmcd_rst_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/pmcd_rst_seq.sv
// PMCD reset/release sequencer: waits for filtered DCM lock, holds RST,
// pulses REL, then watches for lock loss.
// Build option: PMCD_RST_SEQ_AUTO_RESTART_EN re-sequences on lock loss in RUN
// instead of faulting.
module pmcd_rst_seq
    import pmcd_rst_seq_pkg::*;
#(
    parameter int LOCK_FILTER     = 4,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int REL_DELAY       = 8,
    parameter int EN_REL          = 1,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       locked,
    output logic       pmcd_rst,
    output logic       pmcd_rel,
    output logic       ready,
    output logic       err,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

`ifdef PMCD_RST_SEQ_AUTO_RESTART_EN
    localparam bit AUTO_RESTART = 1'b1;
`else
    localparam bit AUTO_RESTART = 1'b0;
`endif

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TMR_W-1:0]  TO_VAL    = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]  HOLD_VAL  = TMR_W'(RST_HOLD_CYCLES);
    localparam logic [TMR_W-1:0]  REL_VAL   = TMR_W'(REL_DELAY);

    state_t            cur_state;
    logic [FILT_W-1:0] filt_cnt;
    logic              tmr_done;
    logic              tmr_load;
    logic              tmr_en;
    logic [TMR_W-1:0]  tmr_val;
    logic              go_wait_lock;
    logic              lock_done;
    logic              go_rel;

    assign state = cur_state;

    // Timer reloads on the same edge the FSM enters a timed state.
    always_comb begin
        go_wait_lock = 1'b0;
        lock_done    = 1'b0;
        go_rel       = 1'b0;
        if ((cur_state == IDLE || cur_state == FAULT) && start)
            go_wait_lock = 1'b1;
        if ((cur_state == HOLD_RST || cur_state == WAIT_REL) && !locked)
            go_wait_lock = 1'b1;
        if (cur_state == RUN && !locked && AUTO_RESTART)
            go_wait_lock = 1'b1;
        if (cur_state == WAIT_LOCK && locked && filt_cnt == FILT_LAST)
            lock_done = 1'b1;
        if (cur_state == HOLD_RST && locked && tmr_done && EN_REL != 0)
            go_rel = 1'b1;
        tmr_load = go_wait_lock | lock_done | go_rel;
        tmr_val  = go_wait_lock ? TO_VAL : (lock_done ? HOLD_VAL : REL_VAL);
        tmr_en   = (cur_state == WAIT_LOCK) || (cur_state == HOLD_RST) ||
                   (cur_state == WAIT_REL);
    end

    pmcd_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            pmcd_rst  <= 1'b1;
            pmcd_rel  <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            loss_cnt  <= '0;
            filt_cnt  <= '0;
        end else begin
            pmcd_rel <= 1'b0;
            unique case (cur_state)
                IDLE: begin
                    if (start) begin
                        cur_state <= WAIT_LOCK;
                        filt_cnt  <= '0;
                    end
                end
                WAIT_LOCK: begin
                    // Lock completion outranks a coincident timeout.
                    if (lock_done) begin
                        cur_state <= HOLD_RST;
                        filt_cnt  <= '0;
                    end else if (tmr_done) begin
                        cur_state <= FAULT;
                        err       <= 1'b1;
                        filt_cnt  <= '0;
                    end else if (locked) begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end else begin
                        filt_cnt <= '0;
                    end
                end
                HOLD_RST: begin
                    if (!locked) begin
                        cur_state <= WAIT_LOCK;
                        loss_cnt  <= sat_inc(loss_cnt);
                    end else if (tmr_done) begin
                        pmcd_rst <= 1'b0;
                        if (EN_REL != 0) begin
                            cur_state <= WAIT_REL;
                        end else begin
                            cur_state <= RUN;
                            ready     <= 1'b1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (!locked) begin
                        cur_state <= WAIT_LOCK;
                        pmcd_rst  <= 1'b1;
                        loss_cnt  <= sat_inc(loss_cnt);
                    end else if (tmr_done) begin
                        cur_state <= RUN;
                        pmcd_rel  <= 1'b1;
                        ready     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!locked) begin
                        pmcd_rst <= 1'b1;
                        ready    <= 1'b0;
                        loss_cnt <= sat_inc(loss_cnt);
                        if (AUTO_RESTART) begin
                            cur_state <= WAIT_LOCK;
                        end else begin
                            cur_state <= FAULT;
                            err       <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (start) begin
                        cur_state <= WAIT_LOCK;
                        err       <= 1'b0;
                        filt_cnt  <= '0;
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule
